// File: rtl/seg_buf_arbiter.sv
// seg_buf_arbiter: owns the eight-digit seven-segment buffer and the anode scan.
// Two requesters share the buffer through a round-robin req/gnt arbiter.
// Segments and anodes are active-low.
//
// Handshake: a requester raises req[i] with its cmd/idx/data and holds all of
// them stable until it sees gnt[i]. The command is sampled and executed at the
// edge that sets gnt[i]; gnt[i] is then high for exactly one cycle, during which
// the requester may drop req[i] or present its next command.
module seg_buf_arbiter #(
  parameter int         TICK_DIV = 10000,
  parameter logic [6:0] BLANK    = 7'h7F
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] cmd0,
  input  logic [2:0] idx0,
  input  logic [6:0] data0,
  input  logic [1:0] cmd1,
  input  logic [2:0] idx1,
  input  logic [6:0] data1,
  output logic [1:0] gnt,
  output logic       busy,
  output logic [6:0] HEX,
  output logic [7:0] AN
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_SHR   = 2'b01;
  localparam logic [1:0] CMD_SHL   = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_CLEAR} state_t;

  state_t        state;
  logic [6:0]    digits [8];
  logic          rr_last;
  logic [2:0]    clr_ptr;
  logic [CW-1:0] scan_cnt;

  logic          win;
  logic [1:0]    sel_cmd;
  logic [2:0]    sel_idx;
  logic [6:0]    sel_data;

  // Pick the winner (lone requester, or the one not served last on a tie) and mux its command.
  always_comb begin
    win = 1'b0;
    if (req == 2'b10) begin
      win = 1'b1;
    end else if (req == 2'b11) begin
      win = ~rr_last;
    end
    sel_cmd  = win ? cmd1  : cmd0;
    sel_idx  = win ? idx1  : idx0;
    sel_data = win ? data1 : data0;
  end

  // Arbitration FSM: grants, executes commands on the digit buffer, walks the clear pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      gnt     <= 2'b00;
      busy    <= 1'b0;
      rr_last <= 1'b1;
      clr_ptr <= 3'd0;
      for (int k = 0; k < 8; k++) digits[k] <= BLANK;
    end else begin
      gnt <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (req != 2'b00) begin
            gnt     <= win ? 2'b10 : 2'b01;
            rr_last <= win;
            busy    <= 1'b1;
            state   <= ST_HOLD;
            case (sel_cmd)
              CMD_WRITE: digits[sel_idx] <= sel_data;
              CMD_SHR: begin
                for (int k = 7; k > 0; k--) digits[k] <= digits[k-1];
                digits[0] <= sel_data;
              end
              CMD_SHL: begin
                for (int k = 0; k < 7; k++) digits[k] <= digits[k+1];
                digits[7] <= BLANK;
              end
              default: begin
                clr_ptr <= 3'd0;
                state   <= ST_CLEAR;
              end
            endcase
          end
        end
        ST_HOLD: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        ST_CLEAR: begin
          digits[clr_ptr] <= BLANK;
          clr_ptr         <= clr_ptr + 3'd1;
          if (clr_ptr == 3'd7) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Anode scan: free-running divider, rotate the low anode bit left on every tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      AN       <= 8'hFE;
    end else if (scan_cnt == TICK_LAST) begin
      scan_cnt <= '0;
      AN       <= {AN[6:0], AN[7]};
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  // Segment output: the digit whose anode is low; blank if the anode pattern is not one-hot-low.
  always_comb begin
    HEX = BLANK;
    case (AN)
      8'hFE:   HEX = digits[0];
      8'hFD:   HEX = digits[1];
      8'hFB:   HEX = digits[2];
      8'hF7:   HEX = digits[3];
      8'hEF:   HEX = digits[4];
      8'hDF:   HEX = digits[5];
      8'hBF:   HEX = digits[6];
      8'h7F:   HEX = digits[7];
      default: HEX = BLANK;
    endcase
  end

endmodule

// File: tb/tb_seg_buf_arbiter.sv
// Bench for seg_buf_arbiter: directed vector table, hand-written corner sequences,
// and random two-requester traffic checked every cycle against a reference model.
module tb_seg_buf_arbiter;

  localparam int         TICK_DIV = 5;
  localparam logic [6:0] BLANK    = 7'h7F;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] req;
  logic [1:0] cmd0 = 2'b00, cmd1 = 2'b00;
  logic [2:0] idx0 = 3'd0, idx1 = 3'd0;
  logic [6:0] data0 = 7'h00, data1 = 7'h00;
  logic [1:0] gnt;
  logic       busy;
  logic [6:0] HEX;
  logic [7:0] AN;
  assign req = {req1, req0};

  seg_buf_arbiter #(.TICK_DIV(TICK_DIV), .BLANK(BLANK)) dut (
    .clk(clk), .reset(rst_n), .req(req),
    .cmd0(cmd0), .idx0(idx0), .data0(data0),
    .cmd1(cmd1), .idx1(idx1), .data1(data1),
    .gnt(gnt), .busy(busy), .HEX(HEX), .AN(AN)
  );

  // clock edges since reset release
  int n_edges = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n_edges <= 0;
    else        n_edges <= n_edges + 1;
  end

  int n_cmp = 0;
  int n_err = 0;
  bit done = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    int         r;
    logic [1:0] cmd;
    logic [2:0] idx;
    logic [6:0] data;
    int         pos;
    logic [6:0] seg;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: per-cycle reference of grants, busy, scan position and displayed digit
  task automatic monitor();
    logic [1:0] p_req = 0, p_cmd0 = 0, p_cmd1 = 0, exp_g, c, ex;
    logic [2:0] p_idx0 = 0, p_idx1 = 0, ix;
    logic [6:0] p_dat0 = 0, p_dat1 = 0, dt;
    logic [6:0] m_buf[8];
    logic [7:0] exp_an;
    logic       m_rr = 1'b1, w;
    int         next_free = 1, e, an_i;
    bit         last_clear = 0, ebusy;
    for (int k = 0; k < 8; k++) m_buf[k] = BLANK;
    while (!done) begin
      @(negedge clk);
      if (!rst_n) begin
        for (int k = 0; k < 8; k++) m_buf[k] = BLANK;
        m_rr = 1'b1; next_free = 1; last_clear = 0;
      end else begin
        e = n_edges;
        exp_g = 2'b00;
        if (e >= next_free && p_req != 2'b00) begin
          w = (p_req == 2'b11) ? ~m_rr : p_req[1];
          exp_g = w ? 2'b10 : 2'b01;
          m_rr = w;
          c  = w ? p_cmd1 : p_cmd0;
          ix = w ? p_idx1 : p_idx0;
          dt = w ? p_dat1 : p_dat0;
          case (c)
            2'b00: m_buf[ix] = dt;
            2'b01: begin for (int k = 7; k > 0; k--) m_buf[k] = m_buf[k-1]; m_buf[0] = dt; end
            2'b10: begin for (int k = 0; k < 7; k++) m_buf[k] = m_buf[k+1]; m_buf[7] = BLANK; end
            default: for (int k = 0; k < 8; k++) m_buf[k] = BLANK;
          endcase
          last_clear = (c == 2'b11);
          next_free = e + (last_clear ? 9 : 2);
        end
        ebusy  = (e < next_free - 1);
        an_i   = (e / TICK_DIV) % 8;
        exp_an = ~(8'h01 << an_i);
        chk("gnt", {30'd0, gnt}, {30'd0, exp_g});
        chk("busy", {31'd0, busy}, {31'd0, ebusy});
        chk("an", {24'd0, AN}, {24'd0, exp_an});
        if (!(last_clear && ebusy)) chk("hex", {25'd0, HEX}, {25'd0, m_buf[an_i]});
        if (gnt != 2'b00 && exp_q.size() > 0) begin
          ex = exp_q.pop_front();
          chk("gnt_seq", {30'd0, gnt}, {30'd0, ex});
        end
      end
      p_req = req; p_cmd0 = cmd0; p_cmd1 = cmd1;
      p_idx0 = idx0; p_idx1 = idx1; p_dat0 = data0; p_dat1 = data1;
    end
  endtask

  // driver tasks
  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic issue(input int r, input logic [1:0] c, input logic [2:0] i, input logic [6:0] d);
    bit got = 0;
    @(posedge clk); #1;
    if (r == 0) begin cmd0 = c; idx0 = i; data0 = d; req0 = 1'b1; end
    else        begin cmd1 = c; idx1 = i; data1 = d; req1 = 1'b1; end
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = gnt[r];
    end
    chk("issue_gnt", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
  endtask

  task automatic check_pos(input int p, input logic [6:0] exp);
    logic [7:0] want;
    bit hit = 0;
    want = ~(8'h01 << p);
    for (int k = 0; k < 8 * TICK_DIV + 4 && !hit; k++) begin
      @(negedge clk);
      hit = (AN == want);
    end
    chk("an_reach", {31'd0, hit}, 32'd1);
    chk("digit", {25'd0, HEX}, {25'd0, exp});
  endtask

  task automatic rand_cmd(input int r);
    int sel;
    logic [1:0] c;
    sel = $urandom_range(0, 9);
    c = (sel < 4) ? 2'b00 : (sel < 7) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
    if (r == 0) begin
      cmd0 = c; idx0 = 3'($urandom_range(0, 7)); data0 = 7'($urandom_range(0, 127)); req0 = 1'b1;
    end else begin
      cmd1 = c; idx1 = 3'($urandom_range(0, 7)); data1 = 7'($urandom_range(0, 127)); req1 = 1'b1;
    end
  endtask

  task automatic run_tests();
    int ng, last_t, nb;
    bit got;
    logic [1:0] g;

    // reset values and scan rotation
    do_reset();
    @(negedge clk);
    chk("rst_an", {24'd0, AN}, 32'hFE);
    chk("rst_hex", {25'd0, HEX}, 32'h7F);
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    repeat (TICK_DIV) @(posedge clk);
    @(negedge clk);
    chk("scan_1", {24'd0, AN}, 32'hFD);
    repeat (7 * TICK_DIV) @(posedge clk);
    @(negedge clk);
    chk("scan_8", {24'd0, AN}, 32'hFE);

    // single-command vectors: {requester, cmd, idx, data, digit to inspect, its expected code}
    vecs[0] = '{0, 2'b00, 3'd3, 7'h40, 3, 7'h40};
    vecs[1] = '{0, 2'b01, 3'd0, 7'h79, 4, 7'h40};
    vecs[2] = '{1, 2'b01, 3'd0, 7'h24, 1, 7'h79};
    vecs[3] = '{0, 2'b10, 3'd0, 7'h00, 0, 7'h79};
    vecs[4] = '{1, 2'b00, 3'd7, 7'h12, 7, 7'h12};
    vecs[5] = '{1, 2'b10, 3'd0, 7'h00, 6, 7'h12};
    vecs[6] = '{0, 2'b11, 3'd0, 7'h00, 3, 7'h7F};
    for (int v = 0; v < 7; v++) begin
      issue(vecs[v].r, vecs[v].cmd, vecs[v].idx, vecs[v].data);
      check_pos(vecs[v].pos, vecs[v].seg);
    end

    // round-robin with both requesters held
    do_reset();
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    @(posedge clk); #1;
    cmd0 = 2'b00; idx0 = 3'd0; data0 = 7'h01; req0 = 1'b1;
    cmd1 = 2'b00; idx1 = 3'd1; data1 = 7'h02; req1 = 1'b1;
    ng = 0; last_t = 0;
    for (int k = 0; k < 30 && ng < 4; k++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        if (ng > 0) chk("rr_spacing", k - last_t, 32'd2);
        last_t = k;
        ng++;
      end
    end
    chk("rr_count", ng, 32'd4);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;

    // clear from requester 1 while requester 0 waits
    for (int i = 0; i < 8; i++) issue(0, 2'b00, 3'(i), 7'(7'h30 + i));
    exp_q.push_back(2'b10); exp_q.push_back(2'b01);
    @(posedge clk); #1;
    cmd0 = 2'b00; idx0 = 3'd5; data0 = 7'h08; req0 = 1'b1;
    cmd1 = 2'b11; req1 = 1'b1;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = (gnt != 2'b00);
    end
    chk("clr_gnt", {30'd0, gnt}, 32'h2);
    nb = busy ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      req1 = 1'b0;
      @(negedge clk);
      if (!busy) break;
      nb++;
    end
    chk("clr_busy_len", nb, 32'd8);
    chk("clr_idle_gnt", {30'd0, gnt}, 32'd0);
    @(negedge clk);
    chk("clr_next_gnt", {30'd0, gnt}, 32'h1);
    @(posedge clk); #1;
    req0 = 1'b0;
    check_pos(0, 7'h7F);
    check_pos(5, 7'h08);
    check_pos(7, 7'h7F);

    // asynchronous reset in the middle of a clear
    for (int i = 0; i < 8; i++) issue(0, 2'b00, 3'(i), 7'(7'h01 + i));
    @(posedge clk); #1;
    cmd1 = 2'b11; req1 = 1'b1;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = gnt[1];
    end
    chk("mid_clr_gnt", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    req1 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_clr_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_an", {24'd0, AN}, 32'hFE);
    chk("arst_hex", {25'd0, HEX}, 32'h7F);
    chk("arst_gnt", {30'd0, gnt}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    do_reset();
    check_pos(6, 7'h7F);

    // random traffic from both requesters
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      g = gnt;
      @(posedge clk); #1;
      if (req0) begin
        if (g[0]) begin
          if ($urandom_range(0, 1) == 1) rand_cmd(0);
          else req0 = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) rand_cmd(0);
      if (req1) begin
        if (g[1]) begin
          if ($urandom_range(0, 1) == 1) rand_cmd(1);
          else req1 = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) rand_cmd(1);
    end
    // let any accepted request finish
    @(posedge clk); #1;
    for (int k = 0; k < 40 && req != 2'b00; k++) begin
      @(negedge clk);
      g = gnt;
      @(posedge clk); #1;
      if (g[0]) req0 = 1'b0;
      if (g[1]) req1 = 1'b0;
    end
    chk("drain", {30'd0, req}, 32'd0);
    repeat (12) @(posedge clk);
    done = 1;
  endtask

  initial begin
    fork
      monitor();
      run_tests();
    join
    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
